// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
// Shares one signed 32x32 Booth multiplier between two requesters.
// Round-robin grant on contention, operands captured at grant, multiplier
// sequenced with a start pulse, product returned over valid/ready.
//
// Optional feature macro: MUL_ARB_TIMEOUT_EN
//   When defined, a 7-bit watchdog ends a BUSY phase after TMO_CYC cycles
//   with a zero product and rsp_err=1. When undefined, BUSY waits forever
//   for mul_done and rsp_err is always 0.
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int W       = 32,
    parameter int PW      = 67,
    parameter int TMO_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [1:0]    req,
    input  logic [W-1:0]  x0,
    input  logic [W-1:0]  y0,
    input  logic [W-1:0]  x1,
    input  logic [W-1:0]  y1,
    output logic [1:0]    ack,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [PW-1:0] rsp_product,
    output logic          rsp_err,
    output logic          mul_start,
    output logic [W-1:0]  mul_x,
    output logic [W-1:0]  mul_y,
    input  logic          mul_done,
    input  logic [PW-1:0] mul_product,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nx_s;
    logic   rr_ptr_r;      // requester favoured on the next contended grant
    logic   owner_r;       // requester that owns the in-flight operation
    logic   grant_s;       // a grant happens on this edge
    logic   grant_idx_s;   // which requester wins
    logic   done_acc_s;    // multiplier completion accepted
    logic   tmo_s;         // watchdog expiry accepted
    logic   hs_s;          // response handshake with the owner
    logic   tmo_hit_s;     // watchdog has reached its limit

`ifdef MUL_ARB_TIMEOUT_EN
    logic [6:0] wdog_r;

    assign tmo_hit_s = (wdog_r == 7'(TMO_CYC - 1));

    // Watchdog: zeroed with the start pulse, counts every BUSY cycle after it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wdog_r <= 7'd0;
        end else if (state_r == ST_ISSUE) begin
            wdog_r <= 7'd0;
        end else if ((state_r == ST_BUSY) && !tmo_hit_s) begin
            wdog_r <= wdog_r + 7'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and per-cycle event decode
    always_comb begin
        state_nx_s  = state_r;
        grant_s     = 1'b0;
        grant_idx_s = 1'b0;
        done_acc_s  = 1'b0;
        tmo_s       = 1'b0;
        hs_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_s = 1'b1;
                    if (req == 2'b11) begin
                        grant_idx_s = rr_ptr_r;
                    end else begin
                        grant_idx_s = req[1];
                    end
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_BUSY;
            end
            ST_BUSY: begin
                // A done coinciding with our own start pulse cannot belong
                // to this operation, so it is not taken as completion.
                if (mul_done && !mul_start) begin
                    done_acc_s = 1'b1;
                    state_nx_s = ST_RESP;
                end else if (tmo_hit_s) begin
                    tmo_s      = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_r]) begin
                    hs_s       = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer, and all registered outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 1'b0;
            owner_r     <= 1'b0;
            ack         <= 2'b00;
            rsp_valid   <= 2'b00;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            mul_start   <= 1'b0;
            mul_x       <= '0;
            mul_y       <= '0;
            busy        <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            busy      <= (state_nx_s != ST_IDLE);
            mul_start <= (state_r == ST_ISSUE);

            if (grant_s) begin
                owner_r <= grant_idx_s;
                ack     <= grant_idx_s ? 2'b10 : 2'b01;
                mul_x   <= grant_idx_s ? x1 : x0;
                mul_y   <= grant_idx_s ? y1 : y0;
            end else begin
                ack     <= 2'b00;
            end

            if (done_acc_s) begin
                rsp_product <= mul_product;
                rsp_valid   <= owner_r ? 2'b10 : 2'b01;
                rsp_err     <= 1'b0;
            end else if (tmo_s) begin
                rsp_product <= '0;
                rsp_valid   <= owner_r ? 2'b10 : 2'b01;
                rsp_err     <= 1'b1;
            end else if (hs_s) begin
                rsp_valid   <= 2'b00;
                rsp_err     <= 1'b0;
                rr_ptr_r    <= ~owner_r;
            end else begin
                rsp_valid   <= rsp_valid;
                rsp_err     <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter
// Directed bench for mul_share_arbiter. Expected grant/product pairs are
// queued when a request is driven and compared when rsp_valid appears.
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

    logic        clk;
    logic        rst_b;
    logic [1:0]  req;
    logic [31:0] x0, y0, x1, y1;
    logic [1:0]  ack;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [66:0] rsp_product;
    logic        rsp_err;
    logic        mul_start;
    logic [31:0] mul_x, mul_y;
    logic        mul_done;
    logic [66:0] mul_product;
    logic        busy;

    typedef struct {
        logic [1:0]  grant;
        logic [66:0] prod;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   rr_exp;

    mul_share_arbiter #(.W(32), .PW(67), .TMO_CYC(64)) dut (
        .clk(clk), .rst_b(rst_b), .req(req),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [66:0] sprod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed(a) * $signed(b);
        return {{3{p[63]}}, p};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   67'(ack),       67'd0);
        chk({tag, "_vld"},   67'(rsp_valid), 67'd0);
        chk({tag, "_prod"},  rsp_product,    67'd0);
        chk({tag, "_err"},   67'(rsp_err),   67'd0);
        chk({tag, "_start"}, 67'(mul_start), 67'd0);
        chk({tag, "_mx"},    67'(mul_x),     67'd0);
        chk({tag, "_my"},    67'(mul_y),     67'd0);
        chk({tag, "_busy"},  67'(busy),      67'd0);
    endtask

    // One full transaction: grant, start, done after lat cycles, bp cycles of
    // backpressure, then the handshake. Inputs change on the falling edge.
    task automatic do_op(input logic [1:0] reqv,
                         input logic [31:0] ax0, input logic [31:0] ay0,
                         input logic [31:0] ax1, input logic [31:0] ay1,
                         input int lat, input int bp, input bit hold, input bit early);
        int          g;
        logic [31:0] ex, ey;
        logic [66:0] held;
        exp_t        e, got;
        g  = (reqv == 2'b11) ? rr_exp : (reqv[1] ? 1 : 0);
        ex = (g == 1) ? ax1 : ax0;
        ey = (g == 1) ? ay1 : ay0;
        e.grant = (g == 1) ? 2'b10 : 2'b01;
        e.prod  = sprod(ex, ey);
        sb.push_back(e);
        req = reqv; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        tick();
        chk("ack", 67'(ack), 67'(e.grant));
        chk("start_pre", 67'(mul_start), 67'd0);
        chk("busy", 67'(busy), 67'd1);
        if (!hold) req[g] = 1'b0;
        tick();
        chk("ack_pulse", 67'(ack), 67'd0);
        chk("start", 67'(mul_start), 67'd1);
        chk("mul_x", 67'(mul_x), 67'(ex));
        chk("mul_y", 67'(mul_y), 67'(ey));
        if (early) begin
            mul_done = 1'b1;
            mul_product = {67{1'b1}};
        end
        tick();
        mul_done = 1'b0;
        chk("start_once", 67'(mul_start), 67'd0);
        chk("early_done_ign", 67'(rsp_valid), 67'd0);
        repeat (lat - 2) tick();
        chk("no_vld_busy", 67'(rsp_valid), 67'd0);
        mul_done = 1'b1;
        mul_product = sprod(mul_x, mul_y);
        tick();
        mul_done = 1'b0;
        mul_product = '0;
        chk("rsp_valid", 67'(rsp_valid), 67'(e.grant));
        chk("rsp_err", 67'(rsp_err), 67'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 67'(sb.size()), 67'd1);
        end else begin
            got = sb.pop_front();
            chk("rsp_product", rsp_product, got.prod);
        end
        held = rsp_product;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = ~e.grant;
            mul_done  = (i == 3);
            mul_product = {67{1'b1}};
            tick();
            chk("bp_vld", 67'(rsp_valid), 67'(e.grant));
            chk("bp_prod", rsp_product, held);
            chk("bp_ack", 67'(ack), 67'd0);
            chk("bp_start", 67'(mul_start), 67'd0);
        end
        mul_done = 1'b0;
        mul_product = '0;
        rsp_ready = e.grant;
        tick();
        rsp_ready = 2'b00;
        chk("hs_vld", 67'(rsp_valid), 67'd0);
        chk("hs_busy", 67'(busy), 67'd0);
        rr_exp = 1 - g;
    endtask

    initial begin
        vectors = 0; miscompares = 0; rr_exp = 0;
        rst_b = 1'b0; req = 2'b00; rsp_ready = 2'b00;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        mul_done = 1'b0; mul_product = '0;
        tick(); tick();
        chk_all_zero("rst");
        rst_b = 1'b1;
        tick();

        // Contention from reset: 0,1,0,1 with both requests held
        do_op(2'b11, 32'd10, 32'd11, 32'd20, 32'd21, 6, 0, 1'b1, 1'b0);
        do_op(2'b11, 32'd10, 32'd11, 32'd20, 32'd21, 6, 0, 1'b1, 1'b0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 5, 0, 1'b1, 1'b1);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 5, 0, 1'b1, 1'b0);
        req = 2'b00;

        // Signed op from requester 1
        do_op(2'b10, 32'd0, 32'd0, 32'hFFFF_FFFB, 32'd7, 12, 0, 1'b0, 1'b0);
        // Single op from requester 0
        do_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd0, 12, 0, 1'b0, 1'b0);
        // Backpressure with non-owner ready and a stray done in RESP
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 8, 20, 1'b0, 1'b0);

        // Request withdrawn before the grant edge
        req = 2'b10;
        #2 req = 2'b00;
        tick();
        chk("drop_ack", 67'(ack), 67'd0);
        chk("drop_busy", 67'(busy), 67'd0);

        // Done while idle
        mul_done = 1'b1; mul_product = 67'd99;
        tick();
        mul_done = 1'b0;
        chk("idle_done_busy", 67'(busy), 67'd0);
        chk("idle_done_vld", 67'(rsp_valid), 67'd0);

        // Reset mid-BUSY (rr_ptr is 1 at this point)
        req = 2'b01; x0 = 32'd1234; y0 = 32'd5;
        tick();
        req = 2'b00;
        tick();
        chk("rb_start", 67'(mul_start), 67'd1);
        repeat (5) tick();
        #2 rst_b = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        rst_b = 1'b1;
        rr_exp = 0;
        mul_done = 1'b1; mul_product = 67'd77;
        tick();
        mul_done = 1'b0;
        chk("late_done_busy", 67'(busy), 67'd0);
        chk("late_done_vld", 67'(rsp_valid), 67'd0);
        do_op(2'b11, 32'd3, 32'd4, 32'd5, 32'd6, 4, 0, 1'b0, 1'b0);
        req = 2'b00;

        // Multiplier never answers
        req = 2'b01; x0 = 32'd9; y0 = 32'd9;
        tick();
        req = 2'b00;
        tick();
        chk("tmo_start", 67'(mul_start), 67'd1);
`ifdef MUL_ARB_TIMEOUT_EN
        repeat (63) tick();
        chk("tmo_early", 67'(rsp_valid), 67'd0);
        tick();
        chk("tmo_vld", 67'(rsp_valid), 67'd1);
        chk("tmo_err", 67'(rsp_err), 67'd1);
        chk("tmo_prod", rsp_product, 67'd0);
        mul_done = 1'b1; mul_product = 67'd5;
        tick();
        mul_done = 1'b0;
        chk("tmo_late_prod", rsp_product, 67'd0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("tmo_err_clr", 67'(rsp_err), 67'd0);
        chk("tmo_hs_vld", 67'(rsp_valid), 67'd0);
`else
        repeat (80) tick();
        chk("hang_busy", 67'(busy), 67'd1);
        chk("hang_vld", 67'(rsp_valid), 67'd0);
        chk("hang_err", 67'(rsp_err), 67'd0);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        chk("hang_rst_busy", 67'(busy), 67'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
